// File: rtl/shift_result_stage_pkg.sv
// Shared definitions for the shift/rotate result stage: operand widths, opcodes
// and the per-entry record held in the result buffer.
package shift_result_stage_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 3;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              neg;
    logic              carry;
  } entry_t;

endpackage

// File: rtl/shift_result_stage_carry_calc.sv
// Combinational carry-out derivation for one shifter transaction.
// A zero shift count leaves the carry unchanged from the previous push.
module shift_carry_calc
  import shift_result_stage_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] result,
  input  logic [CNT_W-1:0]  shift_count,
  input  logic [1:0]        operation,
  input  logic              carry_state,
  output logic              carry
);

  logic [CNT_W:0]   shl_idx;
  logic [CNT_W-1:0] shr_idx;

  // Shifts take the last bit pushed out of the operand; rotates take the bit
  // that wrapped around, which is visible at the opposite end of the result.
  always_comb begin
    shl_idx = (CNT_W+1)'(DATA_W) - {1'b0, shift_count};
    shr_idx = shift_count - CNT_W'(1);
    carry   = carry_state;
    if (shift_count != '0) begin
      case (operation)
        OP_SHL:  carry = data[shl_idx[CNT_W-1:0]];
        OP_SHR:  carry = data[shr_idx];
        OP_ROL:  carry = result[0];
        default: carry = result[DATA_W-1];
      endcase
    end
  end

endmodule

// File: rtl/shift_result_stage.sv
// Registered result stage behind the shift/rotate unit: computes flags at push
// time and queues entries in a small in-order buffer with valid/ready on both sides.
module shift_result_stage
  import shift_result_stage_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data,
  input  logic [CNT_W-1:0]  shiftCount,
  input  logic [1:0]        operation,
  input  logic [DATA_W-1:0] result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_neg,
  output logic              out_carry
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head_q;
  entry_t           head_next;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [PTR_W:0]   occ;
  logic [PTR_W:0]   occ_next;
  logic             carry_state;
  logic             new_carry;
  logic             push;
  logic             pop;

  shift_carry_calc u_carry (
    .data        (data),
    .result      (result),
    .shift_count (shiftCount),
    .operation   (operation),
    .carry_state (carry_state),
    .carry       (new_carry)
  );

  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_valid  = (occ != '0);
  assign rd_ptr_inc = rd_ptr + PTR_W'(1);

  assign new_entry.result = result;
  assign new_entry.zero   = (result == '0);
  assign new_entry.neg    = result[DATA_W-1];
  assign new_entry.carry  = new_carry;

  // Outputs come from a head register rather than the RAM so they hold the
  // last shown entry once the buffer drains.
  always_comb begin
    occ_next  = occ;
    head_next = head_q;
    if (push && !pop) begin
      occ_next = occ + 1'b1;
    end else if (!push && pop) begin
      occ_next = occ - 1'b1;
    end
    if (occ_next != '0) begin
      if ((occ == '0) || (pop && (occ == (PTR_W+1)'(1)))) begin
        head_next = new_entry;
      end else if (pop) begin
        head_next = mem[rd_ptr_inc];
      end else begin
        head_next = mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (!clear && push) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  // Clear flushes occupancy and carry history but leaves the head register
  // alone, so the outputs keep their last value while out_valid is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      in_ready    <= 1'b1;
      carry_state <= 1'b0;
      head_q      <= '0;
    end else if (clear) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      occ         <= '0;
      in_ready    <= 1'b1;
      carry_state <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        carry_state <= new_carry;
      end
      if (pop) begin
        rd_ptr <= rd_ptr_inc;
      end
      occ      <= occ_next;
      in_ready <= (occ_next < (PTR_W+1)'(DEPTH));
      head_q   <= head_next;
    end
  end

  assign out_result = head_q.result;
  assign out_zero   = head_q.zero;
  assign out_neg    = head_q.neg;
  assign out_carry  = head_q.carry;

endmodule

// File: tb/tb_shift_result_stage.sv
// Self-checking bench for shift_result_stage: directed vector table, hand-written
// backpressure/clear/reset sequences and randomized traffic against a queue model.
module tb_shift_result_stage;

  localparam int DEPTH = 2;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] data;
  logic [2:0] shiftCount;
  logic [1:0] operation;
  logic [7:0] result;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_neg;
  logic       out_carry;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int result;
    bit zero;
    bit neg;
    bit carry;
  } m_entry_t;

  typedef struct {
    bit in_valid;
    bit out_ready;
    int data;
    int cnt;
    int op;
    int res;
    bit exp_valid;
    bit exp_ready;
    int exp_result;
    bit exp_zero;
    bit exp_neg;
    bit exp_carry;
  } vec_t;

  m_entry_t m_q[$];
  m_entry_t m_head;
  bit       m_ready;
  bit       m_carry;

  shift_result_stage #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .shiftCount (shiftCount),
    .operation  (operation),
    .result     (result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_carry  (out_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_shift(int d, int cnt, int op);
    case (op)
      0:       return (d << cnt) & 255;
      1:       return d >> cnt;
      2:       return ((d << cnt) | (d >> (8 - cnt))) & 255;
      default: return ((d >> cnt) | (d << (8 - cnt))) & 255;
    endcase
  endfunction

  function automatic bit ref_carry(int d, int cnt, int op, int res, bit cs);
    if (cnt == 0) return cs;
    case (op)
      0:       return ((d >> (8 - cnt)) & 1) != 0;
      1:       return ((d >> (cnt - 1)) & 1) != 0;
      2:       return (res & 1) != 0;
      default: return ((res >> 7) & 1) != 0;
    endcase
  endfunction

  task automatic check(string name, int actual, int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_head  = '{0, 0, 0, 0};
    m_ready = 1'b1;
    m_carry = 1'b0;
  endtask

  task automatic check_output(string tag);
    check({tag, ".out_valid"},  out_valid,  (m_q.size() > 0));
    check({tag, ".in_ready"},   in_ready,   m_ready);
    check({tag, ".out_result"}, out_result, m_head.result);
    check({tag, ".out_zero"},   out_zero,   m_head.zero);
    check({tag, ".out_neg"},    out_neg,    m_head.neg);
    check({tag, ".out_carry"},  out_carry,  m_head.carry);
  endtask

  // Drives one cycle of inputs, advances the model across the edge and checks #1 later.
  task automatic apply_stimulus(string tag, bit iv, bit ordy, bit clr,
                                int d, int cnt, int op, int res);
    bit       do_push;
    bit       do_pop;
    m_entry_t e;
    in_valid   = iv;
    out_ready  = ordy;
    clear      = clr;
    data       = 8'(d);
    shiftCount = 3'(cnt);
    operation  = 2'(op);
    result     = 8'(res);
    do_push = iv && m_ready;
    do_pop  = (m_q.size() > 0) && ordy;
    @(posedge clk);
    if (clr) begin
      m_q.delete();
      m_carry = 1'b0;
      m_ready = 1'b1;
    end else begin
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.result = res;
        e.zero   = (res == 0);
        e.neg    = (res >= 128);
        e.carry  = ref_carry(d, cnt, op, res, m_carry);
        m_carry  = e.carry;
        m_q.push_back(e);
      end
      m_ready = (m_q.size() < DEPTH);
      if (m_q.size() > 0) m_head = m_q[0];
    end
    #1;
    check_output(tag);
  endtask

  vec_t vecs[6];

  initial begin
    int d, cnt, op, res;

    vecs[0] = '{1, 1, 8'h81, 1, 0, 8'h02, 1, 1, 8'h02, 0, 0, 1};
    vecs[1] = '{1, 1, 8'h3C, 0, 1, 8'h3C, 1, 1, 8'h3C, 0, 0, 1};
    vecs[2] = '{1, 1, 8'h01, 1, 1, 8'h00, 1, 1, 8'h00, 1, 0, 1};
    vecs[3] = '{1, 1, 8'h01, 1, 3, 8'h80, 1, 1, 8'h80, 0, 1, 1};
    vecs[4] = '{1, 1, 8'h40, 2, 2, 8'h01, 1, 1, 8'h01, 0, 0, 1};
    vecs[5] = '{0, 1, 8'h00, 0, 0, 8'h00, 0, 1, 8'h01, 0, 0, 1};

    rst_n = 1'b0;
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data = '0; shiftCount = '0; operation = '0; result = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: flag rules for each opcode, each entry shown one cycle later.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].in_valid, vecs[i].out_ready, 1'b0,
                     vecs[i].data, vecs[i].cnt, vecs[i].op, vecs[i].res);
      check($sformatf("tbl%0d.valid", i),  out_valid,  vecs[i].exp_valid);
      check($sformatf("tbl%0d.ready", i),  in_ready,   vecs[i].exp_ready);
      check($sformatf("tbl%0d.result", i), out_result, vecs[i].exp_result);
      check($sformatf("tbl%0d.zero", i),   out_zero,   vecs[i].exp_zero);
      check($sformatf("tbl%0d.neg", i),    out_neg,    vecs[i].exp_neg);
      check($sformatf("tbl%0d.carry", i),  out_carry,  vecs[i].exp_carry);
    end

    // Backpressure: A and B fill the buffer, C waits until space frees up.
    apply_stimulus("bpA", 1, 0, 0, 8'h11, 0, 0, 8'hA1);
    apply_stimulus("bpB", 1, 0, 0, 8'h22, 0, 0, 8'hB2);
    check("bp.full_ready", in_ready, 0);
    apply_stimulus("bpC0", 1, 0, 0, 8'h33, 0, 0, 8'hC3);
    check("bp.c_held", in_ready, 0);
    check("bp.head_a", out_result, 8'hA1);
    apply_stimulus("bpPopA", 1, 1, 0, 8'h33, 0, 0, 8'hC3);
    check("bp.head_b", out_result, 8'hB2);
    apply_stimulus("bpPopB", 1, 1, 0, 8'h33, 0, 0, 8'hC3);
    check("bp.head_c", out_result, 8'hC3);
    apply_stimulus("bpPopC", 0, 1, 0, 0, 0, 0, 0);
    check("bp.drained", out_valid, 0);

    // Clear with two entries buffered and a push offered; carry history must reset.
    apply_stimulus("clr1", 1, 0, 0, 8'h81, 1, 0, 8'h02);
    apply_stimulus("clr2", 1, 0, 0, 8'h81, 1, 0, 8'h02);
    apply_stimulus("clr", 1, 0, 1, 8'h81, 1, 0, 8'h02);
    check("clear.valid", out_valid, 0);
    check("clear.ready", in_ready, 1);
    apply_stimulus("clrPush", 1, 1, 0, 8'h55, 0, 0, 8'h55);
    check("clear.carry0", out_carry, 0);
    check("clear.valid1", out_valid, 1);

    // Asynchronous reset mid-cycle with a valid entry showing nonzero flags.
    apply_stimulus("preRst", 1, 0, 0, 8'h01, 1, 3, 8'h80);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst.valid", out_valid, 0);
    check("arst.ready", in_ready, 1);
    check("arst.result", out_result, 0);
    check("arst.flags", {out_zero, out_neg, out_carry}, 0);
    #2;
    rst_n = 1'b1;

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      d   = int'($urandom_range(0, 255));
      cnt = int'($urandom_range(0, 7));
      op  = int'($urandom_range(0, 3));
      res = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 255)) : ref_shift(d, cnt, op);
      apply_stimulus($sformatf("rnd%0d", i), $urandom_range(0, 3) != 0,
                     $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0,
                     d, cnt, op, res);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
